// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection sensor front end.
package traffic_pkg;

   // Per-approach request state.
   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StWait  = 2'b01,
      StServe = 2'b10
   } req_state_e;

   // Light state {EW, NS} the controller starts in: NS green.
   localparam logic [1:0] LiteReset = 2'b01;

   // Next request state. The approach's own green always wins over its sensor.
   function automatic req_state_e next_req_state(input req_state_e state,
                                                  input logic own,
                                                  input logic deb);
      req_state_e nxt;
      nxt = state;
      if (own) begin
         nxt = StServe;
      end else begin
         case (state)
            StIdle:  nxt = deb ? StWait : StIdle;
            // A seen car is never withdrawn while waiting.
            StWait:  nxt = StWait;
            StServe: nxt = deb ? StWait : StIdle;
            default: nxt = StIdle;
         endcase
      end
      return nxt;
   endfunction

endpackage

// File: rtl/car_debounce.sv
// Two-flop synchroniser followed by a persistence-count debouncer for one loop sensor.
module car_debounce #(
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic clock,
   input  logic reset_n,
   input  logic sensor,
   output logic deb
);

   localparam int unsigned CntW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE - 1);

   logic            sync1_q, sync2_q;
   logic            deb_q, deb_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // Bring the asynchronous loop input into the clock domain.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sensor;
         sync2_q <= sync1_q;
      end
   end

   // Accept a new level only after it has differed from deb for DEBOUNCE cycles in a row.
   always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      if (sync2_q == deb_q) begin
         cnt_d = '0;
      end else if (cnt_q == CntLast) begin
         deb_d = sync2_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   // Debounce state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         deb_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         deb_q <= deb_d;
         cnt_q <= cnt_d;
      end
   end

   assign deb = deb_q;

endmodule

// File: rtl/traffic_car_detect.sv
// Sensor front end: debounced, latched EW/NS car requests gated by a minimum green time.
module traffic_car_detect
   import traffic_pkg::*;
#(
   parameter int unsigned DEBOUNCE  = 4,
   parameter int unsigned MIN_GREEN = 8
) (
   input  logic clock,
   input  logic reset_n,
   input  logic ew_sensor,
   input  logic ns_sensor,
   input  logic EWLite,
   input  logic NSLite,
   output logic EWCar,
   output logic NSCar,
   output logic lite_err
);

   localparam int unsigned GreenW = $clog2(MIN_GREEN + 1);
   localparam logic [GreenW-1:0] GreenMax = GreenW'(MIN_GREEN);

   logic              ew_deb, ns_deb;
   req_state_e        ew_state_q, ew_state_d;
   req_state_e        ns_state_q, ns_state_d;
   logic [1:0]        lite_now;
   logic [1:0]        prev_lite_q;
   logic [GreenW-1:0] green_q, green_d;
   logic              err_q, err_d;
   logic              min_met;

   car_debounce #(
      .DEBOUNCE (DEBOUNCE)
   ) u_ew_deb (
      .clock   (clock),
      .reset_n (reset_n),
      .sensor  (ew_sensor),
      .deb     (ew_deb)
   );

   car_debounce #(
      .DEBOUNCE (DEBOUNCE)
   ) u_ns_deb (
      .clock   (clock),
      .reset_n (reset_n),
      .sensor  (ns_sensor),
      .deb     (ns_deb)
   );

   assign lite_now = {EWLite, NSLite};

   // Request FSM next states, green timer and error flag next values.
   always_comb begin
      ew_state_d = next_req_state(ew_state_q, EWLite, ew_deb);
      ns_state_d = next_req_state(ns_state_q, NSLite, ns_deb);
      green_d    = green_q;
      if (lite_now != prev_lite_q) begin
         green_d = '0;
      end else if (green_q != GreenMax) begin
         green_d = green_q + GreenW'(1);
      end
      // Both green or both red is never legal from the controller.
      err_d = err_q | (EWLite == NSLite);
   end

   // Request, timer and error state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ew_state_q  <= StIdle;
         ns_state_q  <= StIdle;
         prev_lite_q <= LiteReset;
         green_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         ew_state_q  <= ew_state_d;
         ns_state_q  <= ns_state_d;
         prev_lite_q <= lite_now;
         green_q     <= green_d;
         err_q       <= err_d;
      end
   end

   // Outputs come from registers only.
   always_comb begin
      min_met  = (green_q == GreenMax);
      EWCar    = (ew_state_q == StWait) & min_met;
      NSCar    = (ns_state_q == StWait) & min_met;
      lite_err = err_q;
   end

endmodule

// File: tb/tb_traffic_car_detect.sv
// Scenario bench for traffic_car_detect: expectations queued with stimulus, popped per edge.
module tb_traffic_car_detect;

   logic clock = 1'b0;
   logic reset_n;
   logic ew_sensor, ns_sensor;
   logic EWLite, NSLite;
   logic EWCar, NSCar, lite_err;

   // Expected outputs {EWCar, NSCar, lite_err}; chk selects which bits matter.
   typedef struct {
      string      tag;
      logic [2:0] chk;
      logic [2:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   traffic_car_detect #(
      .DEBOUNCE  (4),
      .MIN_GREEN (8)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .ew_sensor (ew_sensor),
      .ns_sensor (ns_sensor),
      .EWLite    (EWLite),
      .NSLite    (NSLite),
      .EWCar     (EWCar),
      .NSCar     (NSCar),
      .lite_err  (lite_err)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic void push(input string tag, input logic [2:0] chk, input logic [2:0] val);
      exp_t e;
      e.tag = tag;
      e.chk = chk;
      e.val = val;
      exp_q.push_back(e);
   endfunction

   // Reset with NS green and no cars, then let the green timer saturate.
   task automatic do_reset();
      reset_n   = 1'b0;
      ew_sensor = 1'b0;
      ns_sensor = 1'b0;
      EWLite    = 1'b0;
      NSLite    = 1'b1;
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (12) tick();
   endtask

   task automatic test_reset();
      exp_t       e;
      logic [2:0] obs;
      reset_n   = 1'b0;
      ew_sensor = 1'b1;
      ns_sensor = 1'b1;
      EWLite    = 1'b0;
      NSLite    = 1'b1;
      repeat (3) tick();
      push("reset_hold", 3'b111, 3'b000);
      e   = exp_q.pop_front();
      obs = {EWCar, NSCar, lite_err};
      checks++;
      if ((obs & e.chk) !== (e.val & e.chk)) begin
         errors++;
         $display("FAIL %s: got %b expected %b", e.tag, obs, e.val);
      end
      reset_n = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         // EW waits after edge 7; green timer reaches 8 at edge 8.
         if (i <= 5 || i >= 8) push($sformatf("reset_rel_e%0d", i), 3'b111, {(i >= 8), 2'b00});
         else push($sformatf("reset_rel_e%0d", i), 3'b011, 3'b000);
         tick();
         e   = exp_q.pop_front();
         obs = {EWCar, NSCar, lite_err};
         checks++;
         if ((obs & e.chk) !== (e.val & e.chk)) begin
            errors++;
            $display("FAIL %s: got %b expected %b", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic test_debounce();
      exp_t       e;
      logic [2:0] obs;
      do_reset();
      // Three-cycle pulse never survives the filter.
      for (int i = 0; i < 12; i++) begin
         ew_sensor = (i < 3);
         push($sformatf("glitch_e%0d", i), 3'b100, 3'b000);
         tick();
         e   = exp_q.pop_front();
         obs = {EWCar, NSCar, lite_err};
         checks++;
         if ((obs & e.chk) !== (e.val & e.chk)) begin
            errors++;
            $display("FAIL %s: got %b expected %b", e.tag, obs, e.val);
         end
      end
      // Four stable cycles are accepted; request appears 6 edges after first sample.
      for (int i = 0; i < 10; i++) begin
         ew_sensor = (i < 4);
         push($sformatf("stable_e%0d", i), 3'b111, {(i >= 6), 2'b00});
         tick();
         e   = exp_q.pop_front();
         obs = {EWCar, NSCar, lite_err};
         checks++;
         if ((obs & e.chk) !== (e.val & e.chk)) begin
            errors++;
            $display("FAIL %s: got %b expected %b", e.tag, obs, e.val);
         end
      end
   endtask

   // EW request holds with the car gone; NS car arrives; lights then switch to EW.
   task automatic test_hold_serve();
      exp_t       e;
      logic [2:0] obs;
      for (int i = 0; i <= 8; i++) begin
         ew_sensor = 1'b0;
         ns_sensor = 1'b1;
         if (i == 8) begin
            EWLite = 1'b1;
            NSLite = 1'b0;
         end
         push($sformatf("hold_e%0d", i), 3'b111, {(i < 8), 2'b00});
         tick();
         e   = exp_q.pop_front();
         obs = {EWCar, NSCar, lite_err};
         checks++;
         if ((obs & e.chk) !== (e.val & e.chk)) begin
            errors++;
            $display("FAIL %s: got %b expected %b", e.tag, obs, e.val);
         end
      end
   endtask

   // NS waits from the switch edge but is withheld until 8 cycles of EW green.
   task automatic test_min_green();
      exp_t       e;
      logic [2:0] obs;
      for (int j = 1; j <= 10; j++) begin
         push($sformatf("min_green_t%0d", j), 3'b111, {1'b0, (j >= 8), 1'b0});
         tick();
         e   = exp_q.pop_front();
         obs = {EWCar, NSCar, lite_err};
         checks++;
         if ((obs & e.chk) !== (e.val & e.chk)) begin
            errors++;
            $display("FAIL %s: got %b expected %b", e.tag, obs, e.val);
         end
      end
   endtask

   // EW car arrives during EW green; on return to NS green EW goes straight to waiting.
   task automatic test_serve_to_wait();
      exp_t       e;
      logic [2:0] obs;
      for (int i = 0; i <= 18; i++) begin
         ew_sensor = 1'b1;
         if (i == 8) begin
            EWLite = 1'b0;
            NSLite = 1'b1;
         end
         push($sformatf("serve_wait_e%0d", i), 3'b111, {(i >= 16), (i < 8), 1'b0});
         tick();
         e   = exp_q.pop_front();
         obs = {EWCar, NSCar, lite_err};
         checks++;
         if ((obs & e.chk) !== (e.val & e.chk)) begin
            errors++;
            $display("FAIL %s: got %b expected %b", e.tag, obs, e.val);
         end
      end
   endtask

   // One cycle of both greens sets a sticky error that only reset clears.
   task automatic test_lite_err();
      exp_t       e;
      logic [2:0] obs;
      for (int i = 0; i <= 12; i++) begin
         EWLite = (i == 2);
         NSLite = 1'b1;
         push($sformatf("lite_err_e%0d", i), 3'b111,
              {((i < 2) || (i >= 11)), 1'b0, (i >= 2)});
         tick();
         e   = exp_q.pop_front();
         obs = {EWCar, NSCar, lite_err};
         checks++;
         if ((obs & e.chk) !== (e.val & e.chk)) begin
            errors++;
            $display("FAIL %s: got %b expected %b", e.tag, obs, e.val);
         end
      end
      reset_n = 1'b0;
      #2;
      push("lite_err_in_reset", 3'b111, 3'b000);
      e   = exp_q.pop_front();
      obs = {EWCar, NSCar, lite_err};
      checks++;
      if ((obs & e.chk) !== (e.val & e.chk)) begin
         errors++;
         $display("FAIL %s: got %b expected %b", e.tag, obs, e.val);
      end
      tick();
      reset_n = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         push($sformatf("post_reset_e%0d", i), 3'b111, 3'b000);
         tick();
         e   = exp_q.pop_front();
         obs = {EWCar, NSCar, lite_err};
         checks++;
         if ((obs & e.chk) !== (e.val & e.chk)) begin
            errors++;
            $display("FAIL %s: got %b expected %b", e.tag, obs, e.val);
         end
      end
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_hold_serve();
      test_min_green();
      test_serve_to_wait();
      test_lite_err();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
